// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared ROB tag constants used by the architectural register file
package regfile_pkg;

  localparam int ROB_ENTRY_W = 6;
  localparam logic [ROB_ENTRY_W-1:0] ENTRY_NULL = 6'd32;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - architectural register file with rename tags and commit bypass
module regfile
  import regfile_pkg::*;
#(
  parameter int REG_NUM = 32,
  parameter int XLEN    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rename_en,
  input  logic [4:0]             rename_rd,
  input  logic [ROB_ENTRY_W-1:0] rename_entry,
  input  logic [4:0]             rs1_addr,
  input  logic [4:0]             rs2_addr,
  output logic [XLEN-1:0]        rs1_value,
  output logic [XLEN-1:0]        rs2_value,
  output logic [ROB_ENTRY_W-1:0] rs1_entry,
  output logic [ROB_ENTRY_W-1:0] rs2_entry,
  input  logic                   commit_sgn,
  input  logic [ROB_ENTRY_W-1:0] commit_entry,
  input  logic [ROB_ENTRY_W-1:0] commit_des,
  input  logic [XLEN-1:0]        commit_result,
  input  logic                   flush
);

  logic [XLEN-1:0]        values [REG_NUM];
  logic [ROB_ENTRY_W-1:0] tags   [REG_NUM];

  logic [4:0] commit_idx;
  logic       commit_live;

  assign commit_idx  = commit_des[4:0];
  assign commit_live = rdy && commit_sgn && !commit_des[5] && (commit_idx != 5'd0);

  // A commit whose tag still owns the register is forwarded so issue sees the final value now.
  function automatic logic [ROB_ENTRY_W+XLEN-1:0] read_port(input logic [4:0] addr);
    logic bypass;
    bypass = commit_live && (commit_idx == addr) && (commit_entry == tags[addr]);
    if (rst || addr == 5'd0)
      return {ENTRY_NULL, {XLEN{1'b0}}};
    else if (bypass == TRUE)
      return {ENTRY_NULL, commit_result};
    else
      return {tags[addr], values[addr]};
  endfunction

  always_comb begin
    {rs1_entry, rs1_value} = read_port(rs1_addr);
    {rs2_entry, rs2_value} = read_port(rs2_addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        values[i] <= '0;
        tags[i]   <= ENTRY_NULL;
      end
    end else if (rdy) begin
      if (commit_live) begin
        values[commit_idx] <= commit_result;
        if (tags[commit_idx] == commit_entry)
          tags[commit_idx] <= ENTRY_NULL;
      end
      // Later assignments win: flush over commit-clear, rename over commit-clear.
      if (flush) begin
        for (int i = 0; i < REG_NUM; i++)
          tags[i] <= ENTRY_NULL;
      end else if (rename_en && rename_rd != 5'd0) begin
        tags[rename_rd] <= rename_entry;
      end
    end
  end

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - randomized self-checking bench for regfile against an array model
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rename_en;
  logic [4:0]  rename_rd;
  logic [5:0]  rename_entry;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic [5:0]  rs1_entry;
  logic [5:0]  rs2_entry;
  logic        commit_sgn;
  logic [5:0]  commit_entry;
  logic [5:0]  commit_des;
  logic [31:0] commit_result;
  logic        flush;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_val [32];
  logic [5:0]  m_tag [32];

  regfile #(.REG_NUM(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rename_en(rename_en), .rename_rd(rename_rd), .rename_entry(rename_entry),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_entry(rs1_entry), .rs2_entry(rs2_entry),
    .commit_sgn(commit_sgn), .commit_entry(commit_entry), .commit_des(commit_des),
    .commit_result(commit_result), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 32'd0;
      m_tag[i] = 6'd32;
    end
  endtask

  function automatic void model_read(input logic [4:0] a, output logic [31:0] v, output logic [5:0] e);
    if (rst || a == 5'd0) begin
      v = 32'd0; e = 6'd32;
    end else if (rdy && commit_sgn && commit_des == {1'b0, a} && commit_entry == m_tag[a]) begin
      v = commit_result; e = 6'd32;
    end else begin
      v = m_val[a]; e = m_tag[a];
    end
  endfunction

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (rdy) begin
      if (commit_sgn && commit_des[4:0] != 5'd0) begin
        m_val[commit_des[4:0]] = commit_result;
        if (m_tag[commit_des[4:0]] == commit_entry) m_tag[commit_des[4:0]] = 6'd32;
      end
      if (flush) model_reset_tags();
      else if (rename_en && rename_rd != 5'd0) m_tag[rename_rd] = rename_entry;
    end
  endtask

  task automatic model_reset_tags();
    for (int i = 0; i < 32; i++) m_tag[i] = 6'd32;
  endtask

  task automatic check_reads(input string tag);
    logic [31:0] v;
    logic [5:0]  e;
    #1;
    if (!rdy && commit_sgn) return;
    model_read(rs1_addr, v, e);
    check({tag, "_rs1_val"}, 64'(rs1_value), 64'(v));
    check({tag, "_rs1_ent"}, 64'(rs1_entry), 64'(e));
    model_read(rs2_addr, v, e);
    check({tag, "_rs2_val"}, 64'(rs2_value), 64'(v));
    check({tag, "_rs2_ent"}, 64'(rs2_entry), 64'(e));
  endtask

  task automatic cycle(input string tag);
    check_reads(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rdy = 1'b1; rename_en = 1'b0; rename_rd = '0; rename_entry = '0;
    commit_sgn = 1'b0; commit_entry = '0; commit_des = '0; commit_result = '0; flush = 1'b0;
  endtask

  task automatic do_rename(input logic [4:0] rd, input logic [5:0] ent);
    idle(); rename_en = 1'b1; rename_rd = rd; rename_entry = ent;
  endtask

  task automatic do_commit(input logic [5:0] ent, input logic [4:0] rd, input logic [31:0] res);
    commit_sgn = 1'b1; commit_entry = ent; commit_des = {1'b0, rd}; commit_result = res;
  endtask

  initial begin
    rst = 1'b1; idle(); rs1_addr = 5'd5; rs2_addr = 5'd0;
    model_reset();
    #1;
    check("rst_x5_val", 64'(rs1_value), 64'd0);
    check("rst_x5_ent", 64'(rs1_entry), 64'd32);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    cycle("after_rst");

    do_rename(5'd5, 6'd3); cycle("ren_x5");
    idle(); do_commit(6'd3, 5'd5, 32'hDEADBEEF); rs1_addr = 5'd5;
    #1;
    check("byp_x5_val", 64'(rs1_value), 64'hDEADBEEF);
    check("byp_x5_ent", 64'(rs1_entry), 64'd32);
    cycle("cmt_x5");
    idle();
    #1;
    check("x5_val", 64'(rs1_value), 64'hDEADBEEF);
    check("x5_ent", 64'(rs1_entry), 64'd32);
    cycle("post_x5");

    do_rename(5'd7, 6'd4); cycle("ren_x7a");
    do_rename(5'd7, 6'd9); cycle("ren_x7b");
    idle(); do_commit(6'd4, 5'd7, 32'h11); rs2_addr = 5'd7; cycle("cmt_x7");
    idle();
    #1;
    check("x7_val", 64'(rs2_value), 64'h11);
    check("x7_ent", 64'(rs2_entry), 64'd9);

    do_rename(5'd8, 6'd2); cycle("ren_x8a");
    do_rename(5'd8, 6'd12); do_commit(6'd2, 5'd8, 32'h22); rs1_addr = 5'd8; cycle("ren_cmt_x8");
    idle();
    #1;
    check("x8_val", 64'(rs1_value), 64'h22);
    check("x8_ent", 64'(rs1_entry), 64'd12);

    do_rename(5'd1, 6'd10); cycle("ren_x1");
    do_rename(5'd2, 6'd11); cycle("ren_x2");
    do_rename(5'd3, 6'd13); cycle("ren_x3");
    idle(); flush = 1'b1; rename_en = 1'b1; rename_rd = 5'd4; rename_entry = 6'd20; cycle("flush");
    idle();
    for (int a = 1; a <= 4; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'd8;
      #1;
      check("flush_ent", 64'(rs1_entry), 64'd32);
      check("flush_x8_val", 64'(rs2_value), 64'h22);
    end
    do_rename(5'd0, 6'd5); rs1_addr = 5'd0; cycle("ren_x0");
    idle();
    #1;
    check("x0_ent", 64'(rs1_entry), 64'd32);
    check("x0_val", 64'(rs1_value), 64'd0);

    do_rename(5'd5, 6'd3); cycle("ren_x5b");
    idle(); rdy = 1'b0; do_commit(6'd3, 5'd5, 32'h55); flush = 1'b1; cycle("frozen");
    idle(); rs1_addr = 5'd5;
    #1;
    check("frozen_x5_val", 64'(rs1_value), 64'hDEADBEEF);
    check("frozen_x5_ent", 64'(rs1_entry), 64'd3);

    do_rename(5'd9, 6'd7); do_commit(6'd3, 5'd5, 32'h77); rs1_addr = 5'd5; rs2_addr = 5'd8;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_x5_val", 64'(rs1_value), 64'd0);
    check("midrst_x5_ent", 64'(rs1_entry), 64'd32);
    check("midrst_x8_val", 64'(rs2_value), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; idle();
    #1;
    check("postrst_x8_val", 64'(rs2_value), 64'd0);
    check("postrst_x8_ent", 64'(rs2_entry), 64'd32);
    cycle("postrst");

    for (int n = 0; n < 400; n++) begin
      rdy          = ($urandom % 8) != 0;
      rename_en    = ($urandom % 2) == 0;
      rename_rd    = 5'($urandom);
      rename_entry = 6'($urandom % 32);
      commit_sgn   = ($urandom % 3) != 0;
      commit_des   = {1'b0, 5'($urandom)};
      commit_entry = ($urandom % 2) ? m_tag[commit_des[4:0]] : 6'($urandom % 32);
      commit_result = $urandom;
      flush        = ($urandom % 20) == 0;
      rs1_addr     = ($urandom % 2) ? commit_des[4:0] : 5'($urandom);
      rs2_addr     = ($urandom % 2) ? rename_rd : 5'($urandom);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
